mini_top_level: RTL and testbench



---
 rtl/mini_top_level.sv | 121 ++++++++++++
 tb/tb_mini_top_level.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mini_top_level.sv
// Decode-stage control slice: main decoder plus ALU control decoder,
// registered into an ID/EX-style control register.
module mini_top_level (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Instruction,
    input  logic        Zero,
    output logic [1:0]  ALUOp,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [2:0]  ALUControl
);

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrc;
        logic       regwrite;
        logic [2:0] aluctl;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;

    logic [5:0] opcode;
    logic [5:0] funct;
    ctl_t       dec;
    ctl_t       ctl_q;
    logic       zero_q;

    assign opcode = Instruction[31:26];
    assign funct  = Instruction[5:0];

    always_comb begin
        dec = '0;
        dec.aluctl = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                dec.aluop    = 2'b10;
                dec.regwrite = 1'b1;
            end
            OP_LW: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_SW:           dec.alusrc = 1'b1;
            OP_BEQ, OP_BNE:  dec.aluop  = 2'b01;
            OP_ADDI: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_SLTI: begin
                dec.aluop    = 2'b11;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            default: ;
        endcase

        case (dec.aluop)
            2'b01: dec.aluctl = ALU_SUB;
            2'b11: begin
                case (opcode)
                    OP_ANDI: dec.aluctl = ALU_AND;
                    OP_ORI:  dec.aluctl = ALU_OR;
                    OP_SLTI: dec.aluctl = ALU_SLT;
                    default: dec.aluctl = ALU_ADD;
                endcase
            end
            2'b10: begin
                // an unrecognised funct must never write the register file
                case (funct)
                    6'b100000, 6'b100001: dec.aluctl = ALU_ADD;
                    6'b100010, 6'b100011: dec.aluctl = ALU_SUB;
                    6'b100100:            dec.aluctl = ALU_AND;
                    6'b100101:            dec.aluctl = ALU_OR;
                    6'b100110:            dec.aluctl = ALU_XOR;
                    6'b100111:            dec.aluctl = ALU_NOR;
                    6'b101010:            dec.aluctl = ALU_SLT;
                    default:              dec.regwrite = 1'b0;
                endcase
            end
            default: dec.aluctl = ALU_ADD;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ctl_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            ctl_q  <= dec;
            zero_q <= Zero;
        end
    end

    // zero_q is held for future branch resolution
    logic unused_bits;
    assign unused_bits = ^{Instruction[25:6], zero_q};

    assign ALUOp      = ctl_q.aluop;
    assign ALUSrc     = ctl_q.alusrc;
    assign RegWrite   = ctl_q.regwrite;
    assign ALUControl = ctl_q.aluctl;

endmodule

// File: tb/tb_mini_top_level.sv
// Self-checking bench for mini_top_level: directed vector table,
// reset/latency sequences and randomized decode against a lookup model.
module tb_mini_top_level;

    logic        Clk;
    logic        Rst;
    logic [31:0] Instruction;
    logic        Zero;
    logic [1:0]  ALUOp;
    logic        ALUSrc;
    logic        RegWrite;
    logic [2:0]  ALUControl;

    int n_cmp;
    int n_fail;

    mini_top_level dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Instruction(Instruction),
        .Zero       (Zero),
        .ALUOp      (ALUOp),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .ALUControl (ALUControl)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [6:0]  exp;
    } vec_t;

    vec_t vecs[$];

    // opcode -> {aluop, alusrc, regwrite}
    logic [3:0] main_tab [logic [5:0]];
    logic [2:0] imm_tab  [logic [5:0]];
    logic [2:0] fn_tab   [logic [5:0]];
    logic [5:0] ops[$];
    logic [5:0] fns[$];

    function automatic logic [6:0] model(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        logic [1:0] aop;
        logic       src;
        logic       wr;
        logic [2:0] ctl;
        op = ins[31:26];
        fn = ins[5:0];
        if (main_tab.exists(op)) {aop, src, wr} = main_tab[op];
        else {aop, src, wr} = 4'b0000;
        ctl = 3'b010;
        if (aop == 2'd1) ctl = 3'b110;
        if (aop == 2'd3) ctl = imm_tab[op];
        if (aop == 2'd2) begin
            if (fn_tab.exists(fn)) ctl = fn_tab[fn];
            else wr = 1'b0;
        end
        return {aop, src, wr, ctl};
    endfunction

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {ALUOp, ALUSrc, RegWrite, ALUControl};
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got op=%b src=%b wr=%b ctl=%b, want op=%b src=%b wr=%b ctl=%b",
                     name, act[6:5], act[4], act[3], act[2:0],
                     exp[6:5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [6:0] prev;
        logic [31:0] ins;
        logic [6:0] exp;
        n_cmp  = 0;
        n_fail = 0;

        main_tab[6'b000000] = 4'b10_0_1;
        main_tab[6'b100011] = 4'b00_1_1;
        main_tab[6'b101011] = 4'b00_1_0;
        main_tab[6'b000100] = 4'b01_0_0;
        main_tab[6'b000101] = 4'b01_0_0;
        main_tab[6'b001000] = 4'b00_1_1;
        main_tab[6'b001100] = 4'b11_1_1;
        main_tab[6'b001101] = 4'b11_1_1;
        main_tab[6'b001010] = 4'b11_1_1;
        main_tab[6'b000010] = 4'b00_0_0;
        imm_tab[6'b001100] = 3'b000;
        imm_tab[6'b001101] = 3'b001;
        imm_tab[6'b001010] = 3'b111;
        fn_tab[6'b100000] = 3'b010;
        fn_tab[6'b100001] = 3'b010;
        fn_tab[6'b100010] = 3'b110;
        fn_tab[6'b100011] = 3'b110;
        fn_tab[6'b100100] = 3'b000;
        fn_tab[6'b100101] = 3'b001;
        fn_tab[6'b100110] = 3'b011;
        fn_tab[6'b100111] = 3'b100;
        fn_tab[6'b101010] = 3'b111;
        foreach (main_tab[k]) ops.push_back(k);
        foreach (fn_tab[k]) fns.push_back(k);

        // expected fields: {ALUOp, ALUSrc, RegWrite, ALUControl}
        vecs.push_back('{"add",  32'h00221820, 7'b10_0_1_010});
        vecs.push_back('{"lw",   32'h8C220000, 7'b00_1_1_010});
        vecs.push_back('{"sw",   32'hAC220000, 7'b00_1_0_010});
        vecs.push_back('{"beq",  32'h10220004, 7'b01_0_0_110});
        vecs.push_back('{"sub",  32'h00221822, 7'b10_0_1_110});
        vecs.push_back('{"and",  32'h00221824, 7'b10_0_1_000});
        vecs.push_back('{"or",   32'h00221825, 7'b10_0_1_001});
        vecs.push_back('{"slt",  32'h0022182A, 7'b10_0_1_111});
        vecs.push_back('{"xor",  32'h00221826, 7'b10_0_1_011});
        vecs.push_back('{"nor",  32'h00221827, 7'b10_0_1_100});
        vecs.push_back('{"addu", 32'h00221821, 7'b10_0_1_010});
        vecs.push_back('{"subu", 32'h00221823, 7'b10_0_1_110});
        vecs.push_back('{"ori",  32'h34220005, 7'b11_1_1_001});
        vecs.push_back('{"slti", 32'h28220005, 7'b11_1_1_111});
        vecs.push_back('{"andi", 32'h30220005, 7'b11_1_1_000});
        vecs.push_back('{"addi", 32'h20220005, 7'b00_1_1_010});
        vecs.push_back('{"bne",  32'h14220004, 7'b01_0_0_110});
        vecs.push_back('{"j",    32'h08000010, 7'b00_0_0_010});
        vecs.push_back('{"unkop", 32'hFC000000, 7'b00_0_0_010});
        vecs.push_back('{"badfn", 32'h0022183F, 7'b10_0_0_010});
        vecs.push_back('{"zero",  32'h00000000, 7'b10_0_0_010});

        Rst = 1'b1;
        Zero = 1'b0;
        Instruction = 32'h0;
        step();
        check("reset1", 7'b0);
        step();
        check("reset2", 7'b0);
        Rst = 1'b0;

        // back-to-back; outputs must hold the previous decode until the edge
        prev = 7'b0;
        foreach (vecs[i]) begin
            Instruction = vecs[i].instr;
            Zero = ~Zero;
            #1;
            check({vecs[i].name, "_hold"}, prev);
            step();
            check(vecs[i].name, vecs[i].exp);
            prev = vecs[i].exp;
        end

        // reset mid-stream, then recovery
        Instruction = 32'h00221820;
        step();
        check("pre_rst_add", 7'b10_0_1_010);
        Rst = 1'b1;
        Zero = ~Zero;
        step();
        check("mid_rst", 7'b0);
        Rst = 1'b0;
        Zero = ~Zero;
        step();
        check("post_rst_add", 7'b10_0_1_010);

        for (int i = 0; i < 500; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) != 0)
                ins[31:26] = ops[$urandom_range(0, ops.size() - 1)];
            if ($urandom_range(0, 3) != 0)
                ins[5:0] = fns[$urandom_range(0, fns.size() - 1)];
            Rst = ($urandom_range(0, 15) == 0);
            Zero = 1'($urandom);
            Instruction = ins;
            exp = Rst ? 7'b0 : model(ins);
            step();
            check("rand", exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
